pe_mac_unit: RTL and testbench
==============================

// Module: pe_mac_unit
// PURPOSE
//  Processing element that sits directly downstream of the convolution control FSM.
//  It consumes the FSM's in_en, pe_rst, stride and mux selects (select_m0..3, select0/1).
//  Per window it performs TAPS signed multiply-accumulates of pixel x weight.
//  Each finished window sum is presented on a valid/ready output port.
// PARAMETERS
//  DW        8   signed pixel/weight width
//  AW        20  signed accumulator/result width (AW >= 2*DW)
//  TAPS      9   MACs per window (>= 1)
//  LINE_DLY  4   depth of pixel delay line, counted in in_en events
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  pixel_in     in   DW  signed pixel stream, sampled when in_en=1
//  w_load       in   1   write w_data into weight register w_addr
//  w_addr       in   2   weight register index 0..3
//  w_data       in   DW  signed weight value
//  select_m0..3 in   1   weight select: zero-hot->weight 0; multi-hot->lowest index wins
//  select0      in   1   operand source LSB
//  select1      in   1   operand source MSB
//  in_en        in   1   perform one MAC this cycle; advance delay line and prev-pixel reg
//  pe_rst       in   1   synchronous window clear
//  stride       in   1   1 = present only even-numbered windows (0,2,4..)
//  out_ready    in   1   downstream accepts acc_out
//  acc_out      out  AW  window result, stable while out_valid=1
//  out_valid    out  1   result available
//  busy         out  1   1 in HOLD; FSM must stall in_en
//  ovf          out  1   sticky: accumulation exceeded AW signed range
// BEHAVIOUR
//  - Async reset: acc, acc_out, count, parity, weights, delay line, prev reg -> 0.
//    out_valid=0, busy=0, ovf=0, state=IDLE.
//  - Operand {select1,select0}: 00 pixel_in.
//    01 delay-line tap: the value shifted in LINE_DLY in_en events earlier, read before the shift.
//    10 previous in_en pixel. 11 zero.
//  - Product is DW x DW signed, 2*DW wide, sign-extended to AW.
//  - States and transitions:
//    IDLE: in_en -> acc=product, count=1, latch stride, go to ACC. If TAPS==1, treat as window end.
//    ACC: in_en -> acc+=product, count++.
//    Window end is the in_en at which count reaches TAPS. On that cycle:
//      acc_out<=final sum; parity toggles.
//      If stride latched and window odd: discard, go to IDLE.
//      Otherwise go to HOLD with out_valid=1 on the next cycle (latency 1 after the TAPS-th in_en).
//    HOLD: out_valid=1, busy=1; acc_out held; in_en ignored.
//      out_valid & out_ready -> out_valid=0, go to IDLE on the next cycle.
//  - pe_rst (sync) has priority over in_en and out_ready in all states.
//    Clears acc, count, parity, out_valid, ovf; state=IDLE.
//    Weights and delay line are kept. An unaccepted result is lost.
//  - w_load in the same cycle as in_en: the MAC uses the old weight; the new weight applies next cycle.
//  - in_en with no pe_rst between windows: parity continues across windows.
//    count never exceeds TAPS.
//  - The delay line and prev reg shift only on accepted in_en (not in HOLD).
// CONFIGURATION
//  PE_MAC_SAT_EN defined:
//    the accumulator clamps to +(2^(AW-1)-1) / -(2^(AW-1)); ovf sets on clamp.
//  Undefined:
//    two's-complement wrap at AW bits; ovf still sets when the true sum leaves range.
// TESTING
//  T1 Reset: rst_n low mid-ACC (count=5) -> next edge all outputs 0, IDLE; the next 9 in_en form a fresh window.
//  T2 Basic MAC: w0=2, select_m0=1, src 00, 9 in_en with pixel 3.
//     -> acc_out=54, out_valid=1 one cycle after the 9th in_en.
//  T3 Backpressure: out_ready=0 for 5 cycles with in_en=1.
//     -> acc_out stable, busy=1, delay line unchanged.
//     Then out_ready=1 -> out_valid=0 next cycle, IDLE.
//  T4 Stride: stride=1, 4 back-to-back windows.
//     -> only windows 0 and 2 raise out_valid; window 1 returns directly to IDLE.
//  T5 Overflow: AW=16, pixel=-128, w=-128, 9 taps.
//     -> with SAT_EN acc_out=32767, ovf=1.
//     -> without SAT_EN acc_out=16384, ovf=1.
//  T6 Delay source: src 01, w=1, pixels 1..9 after reset, LINE_DLY=4 -> acc_out=15 (0+0+0+0+1+2+3+4+5).

Source files
------------

// File: rtl/pe_mac_unit_if.sv
// Stream/control bundle between the convolution control FSM (master) and the PE MAC unit (slave).
interface pe_mac_unit_if #(
    parameter int DW = 8,
    parameter int AW = 20
);
    logic signed [DW-1:0] pixel_in;
    logic                 w_load;
    logic [1:0]           w_addr;
    logic signed [DW-1:0] w_data;
    logic                 select_m0, select_m1, select_m2, select_m3;
    logic                 select0, select1;
    logic                 in_en;
    logic                 pe_rst;
    logic                 stride;
    logic                 out_ready;
    logic signed [AW-1:0] acc_out;
    logic                 out_valid;
    logic                 busy;
    logic                 ovf;

    modport master (
        output pixel_in, w_load, w_addr, w_data,
        output select_m0, select_m1, select_m2, select_m3, select0, select1,
        output in_en, pe_rst, stride, out_ready,
        input  acc_out, out_valid, busy, ovf
    );

    modport slave (
        input  pixel_in, w_load, w_addr, w_data,
        input  select_m0, select_m1, select_m2, select_m3, select0, select1,
        input  in_en, pe_rst, stride, out_ready,
        output acc_out, out_valid, busy, ovf
    );
endinterface

// File: rtl/pe_mac_unit.sv
// PE MAC: TAPS signed pixel x weight MACs per window, window sum on a valid/ready port.
// Define PE_MAC_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module pe_mac_unit #(
    parameter int DW       = 8,
    parameter int AW       = 20,
    parameter int TAPS     = 9,
    parameter int LINE_DLY = 4
) (
    input logic          clk,
    input logic          rst_n,
    pe_mac_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    localparam int CW = $clog2(TAPS + 1);
    localparam int PW = 2 * DW;
    localparam int SW = AW + 1;
    localparam logic [CW-1:0]        LAST    = CW'(TAPS - 1);
    localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

    state_t               state_q, state_d;
    logic signed [DW-1:0] w_q   [4];
    logic signed [DW-1:0] dly_q [LINE_DLY];
    logic signed [DW-1:0] prev_q;
    logic signed [AW-1:0] acc_q, acc_out_q;
    logic [CW-1:0]        count_q;
    logic                 parity_q, stride_q, ovf_q;

    logic [1:0]           w_idx;
    logic signed [DW-1:0] opnd, w_sel;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] prod_ext, base, acc_nxt;
    logic signed [SW-1:0] sum;
    logic                 first, mac_en, win_end, discard, ovf_step;

    always_comb begin
        w_idx = 2'd0;
        if (bus.select_m0)      w_idx = 2'd0;
        else if (bus.select_m1) w_idx = 2'd1;
        else if (bus.select_m2) w_idx = 2'd2;
        else if (bus.select_m3) w_idx = 2'd3;
    end

    assign w_sel = w_q[w_idx];

    // Tap 01 reads the oldest delay-line entry before this cycle's shift.
    always_comb begin
        case ({bus.select1, bus.select0})
            2'b00:   opnd = bus.pixel_in;
            2'b01:   opnd = dly_q[LINE_DLY-1];
            2'b10:   opnd = prev_q;
            default: opnd = '0;
        endcase
    end

    assign prod     = PW'(opnd) * PW'(w_sel);
    assign prod_ext = AW'(prod);
    assign first    = (state_q == IDLE);
    assign base     = first ? '0 : acc_q;
    assign sum      = SW'(base) + SW'(prod_ext);
    assign ovf_step = sum[AW] ^ sum[AW-1];

`ifdef PE_MAC_SAT_EN
    assign acc_nxt = ovf_step ? (sum[AW] ? ACC_MIN : ACC_MAX) : sum[AW-1:0];
`else
    assign acc_nxt = sum[AW-1:0];
`endif

    assign mac_en  = bus.in_en & ~bus.pe_rst & (state_q != HOLD);
    assign win_end = mac_en & (first ? (TAPS == 1) : (count_q == LAST));
    // Stride is latched at window start; the first window uses the live input.
    assign discard = (first ? bus.stride : stride_q) & parity_q;

    always_comb begin
        state_d = state_q;
        if (bus.pe_rst) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (mac_en) state_d = win_end ? (discard ? IDLE : HOLD) : ACC;
                ACC:     if (win_end) state_d = discard ? IDLE : HOLD;
                HOLD:    if (bus.out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) w_q[i] <= '0;
            for (int i = 0; i < LINE_DLY; i++) dly_q[i] <= '0;
            prev_q    <= '0;
            acc_q     <= '0;
            acc_out_q <= '0;
            count_q   <= '0;
            parity_q  <= 1'b0;
            stride_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (bus.w_load) w_q[bus.w_addr] <= bus.w_data;
            if (bus.pe_rst) begin
                acc_q    <= '0;
                count_q  <= '0;
                parity_q <= 1'b0;
                ovf_q    <= 1'b0;
            end else if (mac_en) begin
                acc_q   <= acc_nxt;
                count_q <= win_end ? '0 : (first ? CW'(1) : count_q + CW'(1));
                if (first)    stride_q <= bus.stride;
                if (ovf_step) ovf_q    <= 1'b1;
                dly_q[0] <= bus.pixel_in;
                for (int i = 1; i < LINE_DLY; i++) dly_q[i] <= dly_q[i-1];
                prev_q <= bus.pixel_in;
                if (win_end) begin
                    acc_out_q <= acc_nxt;
                    parity_q  <= ~parity_q;
                end
            end
        end
    end

    assign bus.acc_out   = acc_out_q;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.busy      = (state_q == HOLD);
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pe_mac_unit.sv
// Bench for pe_mac_unit: vector table + scoreboard of window results, plus multi-cycle sequences.
module tb_pe_mac_unit;
    localparam int DW   = 8;
    localparam int TAPS = 9;
    localparam int NV   = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pe_mac_unit_if #(.DW(8), .AW(20)) bus ();
    pe_mac_unit_if #(.DW(8), .AW(16)) m16 ();

    pe_mac_unit #(.DW(8), .AW(20), .TAPS(9), .LINE_DLY(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    pe_mac_unit #(.DW(8), .AW(16), .TAPS(9), .LINE_DLY(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .bus(m16));

    typedef struct {
        logic [1:0] src;
        logic [3:0] selm;
        int         p0;
        int         dp;
        int         exp;
    } vec_t;

    vec_t tv [NV];
    int   sb [$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic load_w(input int a, input int v);
        bus.w_load = 1'b1;
        bus.w_addr = 2'(a);
        bus.w_data = DW'(v);
        tick();
        bus.w_load = 1'b0;
    endtask

    task automatic set_sel(input logic [1:0] src, input logic [3:0] selm);
        {bus.select1, bus.select0} = src;
        {bus.select_m3, bus.select_m2, bus.select_m1, bus.select_m0} = selm;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        load_w(0, 2); load_w(1, -3); load_w(2, 5); load_w(3, 1);
    endtask

    task automatic window(input int p0, input int dp, input bit lat);
        for (int k = 0; k < TAPS; k++) begin
            bus.pixel_in = DW'(p0 + k * dp);
            bus.in_en    = 1'b1;
            tick();
            if (lat && k == TAPS - 2) chk("latency_early_valid", bus.out_valid, 0);
        end
        bus.in_en = 1'b0;
    endtask

    // Accept one result and compare against the oldest scoreboard entry.
    task automatic drain(input string nm);
        int t = 0;
        int e;
        bus.out_ready = 1'b1;
        while (!bus.out_valid && t < 20) begin
            tick();
            t++;
        end
        if (t >= 20) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got out_valid 0 expected 1", nm);
        end else if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_sb_empty: got result %0d expected none", nm, bus.acc_out);
        end else begin
            e = sb.pop_front();
            chk(nm, bus.acc_out, e);
        end
        tick();
        bus.out_ready = 1'b0;
        chk({nm, "_released"}, bus.out_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        tv[0]  = '{2'b00, 4'b0001,    3,  0,    54};
        tv[1]  = '{2'b00, 4'b0010,    1,  1,  -135};
        tv[2]  = '{2'b00, 4'b0000,   -5,  0,   -90};
        tv[3]  = '{2'b00, 4'b1100,   10, -2,    90};
        tv[4]  = '{2'b00, 4'b1000,  127,  0,  1143};
        tv[5]  = '{2'b10, 4'b0001,    1,  1,    72};
        tv[6]  = '{2'b01, 4'b1000,    1,  1,    15};
        tv[7]  = '{2'b11, 4'b0001,   50,  0,     0};
        tv[8]  = '{2'b00, 4'b0100, -128,  0, -5760};
        tv[9]  = '{2'b10, 4'b0110,   -4,  1,    12};
        tv[10] = '{2'b01, 4'b0100,    2,  3,   200};

        {bus.pixel_in, bus.w_load, bus.w_addr, bus.w_data} = '0;
        {bus.select_m0, bus.select_m1, bus.select_m2, bus.select_m3} = '0;
        {bus.select0, bus.select1, bus.in_en, bus.pe_rst, bus.stride, bus.out_ready} = '0;
        {m16.pixel_in, m16.w_load, m16.w_addr, m16.w_data} = '0;
        {m16.select_m0, m16.select_m1, m16.select_m2, m16.select_m3} = '0;
        {m16.select0, m16.select1, m16.in_en, m16.pe_rst, m16.stride, m16.out_ready} = '0;
        tick();
        chk("rst_acc_out", bus.acc_out, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ovf", bus.ovf, 0);

        for (int i = 0; i < NV; i++) begin
            do_reset();
            set_sel(tv[i].src, tv[i].selm);
            sb.push_back(tv[i].exp);
            window(tv[i].p0, tv[i].dp, 1'b1);
            chk($sformatf("vec%0d_valid", i), bus.out_valid, 1);
            chk($sformatf("vec%0d_busy", i), bus.busy, 1);
            chk($sformatf("vec%0d_ovf", i), bus.ovf, 0);
            drain($sformatf("vec%0d_acc", i));
        end

        // Weight written alongside the first MAC only takes effect from the second.
        do_reset();
        set_sel(2'b00, 4'b0001);
        bus.pixel_in = DW'(1);
        bus.in_en    = 1'b1;
        bus.w_load   = 1'b1;
        bus.w_addr   = 2'd0;
        bus.w_data   = DW'(4);
        tick();
        bus.w_load = 1'b0;
        sb.push_back(34);
        for (int k = 1; k < TAPS; k++) tick();
        bus.in_en = 1'b0;
        drain("wload_same_cycle");

        // Async reset mid-window, then a fresh window.
        do_reset();
        set_sel(2'b00, 4'b0001);
        bus.pixel_in = DW'(3);
        bus.in_en    = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        bus.in_en = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("t1_acc_out", bus.acc_out, 0);
        chk("t1_valid", bus.out_valid, 0);
        chk("t1_busy", bus.busy, 0);
        chk("t1_ovf", bus.ovf, 0);
        rst_n = 1'b1;
        tick();
        load_w(0, 2);
        sb.push_back(54);
        window(3, 0, 1'b0);
        drain("t1_fresh");

        // pe_rst mid-window wins over in_en; following 9 in_en are a whole window.
        bus.pixel_in = DW'(3);
        bus.in_en    = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        bus.pe_rst = 1'b1;
        tick();
        bus.pe_rst = 1'b0;
        bus.in_en  = 1'b0;
        sb.push_back(54);
        window(3, 0, 1'b1);
        chk("perst_mid_valid", bus.out_valid, 1);
        drain("perst_mid_acc");

        // pe_rst in HOLD drops the unaccepted result.
        window(3, 0, 1'b0);
        chk("perst_hold_pre", bus.out_valid, 1);
        bus.pe_rst = 1'b1;
        tick();
        bus.pe_rst = 1'b0;
        chk("perst_hold_valid", bus.out_valid, 0);
        chk("perst_hold_busy", bus.busy, 0);

        // Backpressure: HOLD ignores in_en, delay line must not advance.
        do_reset();
        set_sel(2'b01, 4'b1000);
        sb.push_back(15);
        window(1, 1, 1'b0);
        bus.pixel_in = DW'(100);
        bus.in_en    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("t3_hold_acc%0d", k), bus.acc_out, 15);
            chk($sformatf("t3_hold_busy%0d", k), bus.busy, 1);
        end
        bus.in_en = 1'b0;
        drain("t3_acc");
        sb.push_back(90);
        window(10, 1, 1'b0);
        drain("t3_dly_kept");

        // Stride: only even windows presented.
        bus.pe_rst = 1'b1;
        tick();
        bus.pe_rst = 1'b0;
        bus.stride = 1'b1;
        set_sel(2'b00, 4'b0001);
        sb.push_back(18);
        window(1, 0, 1'b0);
        chk("t4_w0_valid", bus.out_valid, 1);
        drain("t4_w0_acc");
        window(2, 0, 1'b0);
        chk("t4_w1_valid", bus.out_valid, 0);
        chk("t4_w1_busy", bus.busy, 0);
        sb.push_back(54);
        window(3, 0, 1'b0);
        chk("t4_w2_valid", bus.out_valid, 1);
        drain("t4_w2_acc");
        window(4, 0, 1'b0);
        chk("t4_w3_valid", bus.out_valid, 0);
        bus.stride = 1'b0;

        // Overflow on the 16-bit instance.
        m16.w_load = 1'b1;
        m16.w_addr = 2'd0;
        m16.w_data = DW'(-128);
        tick();
        m16.w_load    = 1'b0;
        m16.select_m0 = 1'b1;
        m16.pixel_in  = DW'(-128);
        m16.in_en     = 1'b1;
        for (int k = 0; k < TAPS; k++) tick();
        m16.in_en = 1'b0;
`ifdef PE_MAC_SAT_EN
        chk("t5_acc", m16.acc_out, 32767);
`else
        chk("t5_acc", m16.acc_out, 16384);
`endif
        chk("t5_ovf", m16.ovf, 1);
        chk("t5_valid", m16.out_valid, 1);
        m16.pe_rst = 1'b1;
        tick();
        m16.pe_rst = 1'b0;
        chk("t5_ovf_cleared", m16.ovf, 0);
        chk("t5_valid_cleared", m16.out_valid, 0);

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
